// File: rtl/elevator_ctrl.sv
// Two-floor elevator request controller: debounced buttons, request latches, trip and dwell timing.
// Optional arrival buzzer built only when ELEV_BUZZER_EN is defined.
module elevator_ctrl #(
    parameter int DEB_TICKS    = 500000,
    parameter int TRAVEL_TICKS = 200000000,
    parameter int DWELL_TICKS  = 100000000,
    parameter int BUZZ_TICKS   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_call1,
    input  logic       btn_call2,
    input  logic       btn_home,
    output logic [3:0] state,
    output logic [1:0] floor,
    output logic       start_stop,
    output logic       busy,
    output logic       buzzer
);
    localparam int DBW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int TW  = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DW  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DBW-1:0] DEB_LAST    = DBW'(DEB_TICKS - 1);
    localparam logic [TW-1:0]  TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0]  DWELL_LAST  = DW'(DWELL_TICKS - 1);
    localparam logic [1:0]     FLOOR1      = 2'd1;
    localparam logic [1:0]     FLOOR2      = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_HOME, S_DWELL} fsm_t;

    logic [2:0] raw;
    logic [2:0] press;
    assign raw = {btn_home, btn_call2, btn_call1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic           sync1_reg;
        logic           sync2_reg;
        logic           deb_reg;
        logic           deb_d_reg;
        logic [DBW-1:0] deb_cnt_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_reg   <= 1'b0;
                sync2_reg   <= 1'b0;
                deb_reg     <= 1'b0;
                deb_d_reg   <= 1'b0;
                deb_cnt_reg <= '0;
            end else begin
                sync1_reg <= raw[gi];
                sync2_reg <= sync1_reg;
                deb_d_reg <= deb_reg;
                if (sync2_reg == deb_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_reg     <= sync2_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end
        end

        assign press[gi] = deb_reg & ~deb_d_reg;
    end

    fsm_t          fsm_reg, fsm_next;
    logic [1:0]    floor_reg, floor_next;
    logic          req1_reg, req1_next;
    logic          req2_reg, req2_next;
    logic          home_reg, home_next;
    logic [TW-1:0] trip_cnt_reg, trip_cnt_next;
    logic [DW-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [3:0]    code_reg, code_next;
    logic          start_stop_reg, start_stop_next;
    logic          busy_reg, busy_next;
    logic          at_rest;

    assign at_rest = (fsm_reg == S_IDLE) || (fsm_reg == S_DWELL);

    always_comb begin
        fsm_next       = fsm_reg;
        floor_next     = floor_reg;
        trip_cnt_next  = trip_cnt_reg;
        dwell_cnt_next = dwell_cnt_reg;
        // A call for the floor the parked car already occupies is dropped.
        req1_next = req1_reg | (press[0] & ~(at_rest & (floor_reg == FLOOR1)));
        req2_next = req2_reg | (press[1] & ~(at_rest & (floor_reg == FLOOR2)));
        home_next = home_reg | press[2];
        case (fsm_reg)
            S_IDLE: begin
                if (home_reg && floor_reg == FLOOR2) fsm_next = S_HOME;
                else if (home_reg) home_next = 1'b0;
                else if (floor_reg == FLOOR1 && req2_reg) fsm_next = S_UP;
                else if (floor_reg == FLOOR2 && req1_reg) fsm_next = S_DOWN;
            end
            S_UP: begin
                if (trip_cnt_reg == TRAVEL_LAST) begin
                    floor_next = FLOOR2;
                    req2_next  = 1'b0;
                    fsm_next   = S_DWELL;
                end else begin
                    trip_cnt_next = trip_cnt_reg + 1'b1;
                end
            end
            S_DOWN: begin
                if (trip_cnt_reg == TRAVEL_LAST) begin
                    floor_next = FLOOR1;
                    req1_next  = 1'b0;
                    fsm_next   = S_DWELL;
                end else begin
                    trip_cnt_next = trip_cnt_reg + 1'b1;
                end
            end
            S_HOME: begin
                if (trip_cnt_reg == TRAVEL_LAST) begin
                    floor_next = FLOOR1;
                    req1_next  = 1'b0;
                    home_next  = 1'b0;
                    fsm_next   = S_IDLE;
                end else begin
                    trip_cnt_next = trip_cnt_reg + 1'b1;
                end
            end
            S_DWELL: begin
                if (home_reg || dwell_cnt_reg == DWELL_LAST) fsm_next = S_IDLE;
                else dwell_cnt_next = dwell_cnt_reg + 1'b1;
            end
            default: fsm_next = S_IDLE;
        endcase
        if (fsm_next != fsm_reg) begin
            trip_cnt_next  = '0;
            dwell_cnt_next = '0;
        end
    end

    // Outputs are decoded from the next state so they leave the block registered.
    always_comb begin
        code_next       = 4'd0;
        start_stop_next = 1'b0;
        busy_next       = (fsm_next != S_IDLE);
        case (fsm_next)
            S_UP:    begin code_next = 4'd1; start_stop_next = 1'b1; end
            S_DOWN:  begin code_next = 4'd2; start_stop_next = 1'b1; end
            S_HOME:  begin code_next = 4'd3; start_stop_next = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_reg        <= S_IDLE;
            floor_reg      <= FLOOR1;
            req1_reg       <= 1'b0;
            req2_reg       <= 1'b0;
            home_reg       <= 1'b0;
            trip_cnt_reg   <= '0;
            dwell_cnt_reg  <= '0;
            code_reg       <= 4'd0;
            start_stop_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            fsm_reg        <= fsm_next;
            floor_reg      <= floor_next;
            req1_reg       <= req1_next;
            req2_reg       <= req2_next;
            home_reg       <= home_next;
            trip_cnt_reg   <= trip_cnt_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            code_reg       <= code_next;
            start_stop_reg <= start_stop_next;
            busy_reg       <= busy_next;
        end
    end

    assign state      = code_reg;
    assign floor      = floor_reg;
    assign start_stop = start_stop_reg;
    assign busy       = busy_reg;

`ifdef ELEV_BUZZER_EN
    localparam int BW = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS) : 1;
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_TICKS - 1);

    logic          arrive;
    logic          arrive_reg;
    logic          buzzer_reg;
    logic [BW-1:0] buzz_cnt_reg;

    assign arrive = (fsm_reg == S_UP || fsm_reg == S_DOWN || fsm_reg == S_HOME)
                    && (trip_cnt_reg == TRAVEL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arrive_reg   <= 1'b0;
            buzzer_reg   <= 1'b0;
            buzz_cnt_reg <= '0;
        end else begin
            arrive_reg <= arrive;
            if (arrive_reg) begin
                buzzer_reg   <= 1'b1;
                buzz_cnt_reg <= '0;
            end else if (buzzer_reg) begin
                if (buzz_cnt_reg == BUZZ_LAST) buzzer_reg <= 1'b0;
                else buzz_cnt_reg <= buzz_cnt_reg + 1'b1;
            end
        end
    end

    assign buzzer = buzzer_reg;
`else
    // Without the buzzer option the pulse length has no effect.
    assign buzzer = 1'b0 & (BUZZ_TICKS > 0);
`endif

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: a trip-level model pushes expected trips, a monitor pops and compares.
module tb_elevator_ctrl;
    localparam int DEB    = 4;
    localparam int TRAVEL = 20;
    localparam int DWELL  = 8;
    localparam int BUZZ   = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_call1 = 1'b0;
    logic       btn_call2 = 1'b0;
    logic       btn_home = 1'b0;
    logic [3:0] state;
    logic [1:0] floor;
    logic       start_stop;
    logic       busy;
    logic       buzzer;

    elevator_ctrl #(
        .DEB_TICKS(DEB), .TRAVEL_TICKS(TRAVEL), .DWELL_TICKS(DWELL), .BUZZ_TICKS(BUZZ)
    ) dut (
        .clk(clk), .reset(reset), .btn_call1(btn_call1), .btn_call2(btn_call2),
        .btn_home(btn_home), .state(state), .floor(floor), .start_stop(start_stop),
        .busy(busy), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int len; int fl; int dwell; } trip_t;
    trip_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int m_floor = 1;

    int phase = 0;
    int tlen, tcode, tfloor, tdwell;
    bit code_ok;
    int cyc = 0;
    int arr_cyc = -100;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [2:0] call_mask(input int f);
        return (f == 1) ? 3'b001 : 3'b010;
    endfunction

    // Trip to floor tgt: up trips report state 1, down trips state 2.
    function automatic void push_go(input int tgt, input int dwell);
        trip_t t;
        t.code = (tgt == 2) ? 1 : 2;
        t.len = TRAVEL; t.fl = tgt; t.dwell = dwell;
        exp_q.push_back(t);
        m_floor = tgt;
    endfunction

    function automatic void push_home();
        trip_t t;
        t.code = 3; t.len = TRAVEL; t.fl = 1; t.dwell = 0;
        exp_q.push_back(t);
        m_floor = 1;
    endfunction

    function automatic void emit();
        trip_t e;
        $display("trip: state=%0d len=%0d floor=%0d dwell=%0d", tcode, tlen, tfloor, tdwell);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_trip: got trip with state %0d, required no trip", tcode);
            return;
        end
        e = exp_q.pop_front();
        chk("trip_state", tcode, e.code);
        chk("trip_state_steady", {31'd0, code_ok}, 1);
        chk("trip_len", tlen, e.len);
        chk("arrive_floor", tfloor, e.fl);
        chk("dwell_len", tdwell, e.dwell);
    endfunction

    // Monitor: reconstructs trips from the outputs and checks buzzer and invariants every cycle.
    always @(negedge clk) begin
        bit exp_bz;
        bit inv_ok;
        cyc++;
        if (!reset) begin
            phase = 0;
            arr_cyc = -100;
        end else begin
            case (phase)
                0: if (start_stop) begin phase = 1; tlen = 1; tcode = state; code_ok = 1; end
                1: begin
                    if (start_stop) begin
                        tlen++;
                        if (state != tcode) code_ok = 0;
                    end else begin
                        tfloor = floor; arr_cyc = cyc; tdwell = 0;
                        if (busy) begin tdwell = 1; phase = 2; end
                        else begin emit(); phase = 0; end
                    end
                end
                default: begin
                    if (busy && !start_stop) tdwell++;
                    else begin
                        emit();
                        if (start_stop) begin phase = 1; tlen = 1; tcode = state; code_ok = 1; end
                        else phase = 0;
                    end
                end
            endcase
`ifdef ELEV_BUZZER_EN
            exp_bz = (cyc > arr_cyc) && (cyc <= arr_cyc + BUZZ);
`else
            exp_bz = 1'b0;
`endif
            chk("buzzer", {31'd0, buzzer}, {31'd0, exp_bz});
            inv_ok = (floor === 2'd1 || floor === 2'd2) && (state <= 4'd3)
                     && (start_stop === (state != 4'd0)) && (!start_stop || busy);
            chk("invariants", {31'd0, inv_ok}, 1);
        end
    end

    task automatic hold(input logic [2:0] m, input int n);
        btn_call1 = m[0]; btn_call2 = m[1]; btn_home = m[2];
        repeat (n) @(posedge clk);
        #1;
        btn_call1 = 1'b0; btn_call2 = 1'b0; btn_home = 1'b0;
    endtask

    task automatic wait_trip_start();
        int n = 0;
        while (start_stop !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("trip_started", {31'd0, start_stop}, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        bit ok;
        repeat (DEB + 8) @(posedge clk);
        while (!(exp_q.size() == 0 && phase == 0 && busy === 1'b0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        ok = (exp_q.size() == 0) && (phase == 0) && (busy === 1'b0);
        chk("reach_idle", {31'd0, ok}, 1);
        if (!ok) exp_q.delete();
    endtask

    task automatic run_scn(input int k);
        int other, orig, tgt;
        logic [2:0] m;
        wait_idle();
        other = (m_floor == 1) ? 2 : 1;
        orig = m_floor;
        $display("scenario %0d from floor %0d", k, m_floor);
        case (k)
            0: begin
                tgt = $urandom_range(0, 2);
                m = 3'b001 << tgt;
                hold(m, $urandom_range(1, DEB - 1));
            end
            1: begin
                tgt = $urandom_range(1, 2);
                if (tgt != m_floor) push_go(tgt, DWELL);
                hold(call_mask(tgt), DEB + 6);
            end
            2: begin
                if (m_floor == 2) push_home();
                hold(3'b100, DEB + 6);
            end
            3: begin
                push_go(other, DWELL);
                push_go(orig, DWELL);
                hold(call_mask(other), DEB + 6);
                wait_trip_start();
                repeat (2) @(posedge clk);
                #1;
                hold(call_mask(orig), DEB + 6);
            end
            4: begin
                push_go(other, 1);
                if (other == 2) push_home();
                hold(call_mask(other), DEB + 6);
                wait_trip_start();
                repeat (2) @(posedge clk);
                #1;
                hold(3'b100, DEB + 6);
            end
            default: begin
                push_go(other, DWELL);
                hold(3'b011, DEB + 6);
            end
        endcase
    endtask

    task automatic reset_scn();
        wait_idle();
        if (m_floor == 2) begin
            push_go(1, DWELL);
            hold(3'b001, DEB + 6);
            wait_idle();
        end
        $display("scenario reset during up trip");
        hold(3'b010, DEB + 6);
        wait_trip_start();
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_floor", floor, 1);
        chk("abort_start_stop", {31'd0, start_stop}, 0);
        chk("abort_buzzer", {31'd0, buzzer}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        m_floor = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_abort_state", state, 0);
        chk("post_abort_busy", {31'd0, busy}, 0);
        chk("post_abort_floor", floor, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_floor", floor, 1);
        chk("reset_start_stop", {31'd0, start_stop}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_buzzer", {31'd0, buzzer}, 0);
        reset = 1'b1;
        $display("scenario call1 at floor 1");
        hold(3'b001, DEB + 6);
        for (int i = 0; i < 6; i++) run_scn(i);
        for (int i = 0; i < 40; i++) run_scn($urandom_range(0, 5));
        reset_scn();
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
